// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: a single request/ready handshake
// carrying word address, byte enables and lane-replicated write data.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: stalls the core while one memory access is in flight, aligns
// and extends load data, and flags misaligned, illegal or timed-out accesses.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      stall,
    output logic [31:0]               rdata,
    output logic                      fault,
    load_store_unit_if.master         mem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } req_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access, f3_ok, aligned, req_ok, req_bad;
    logic [3:0]  new_be;
    logic [31:0] new_wdata;
    logic [31:0] shifted, ld_data;

    // Decode of the incoming access; reset masks it so nothing starts or faults.
    always_comb begin
        access = (MemRead | MemWrite) & ~reset;
        unique case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~MemWrite;
            default:                f3_ok = 1'b0;
        endcase
        unique case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        req_ok  = access & f3_ok & aligned;
        req_bad = access & ~(f3_ok & aligned);

        new_be    = 4'b1111;
        new_wdata = '0;
        if (MemWrite) begin
            unique case (funct3[1:0])
                2'b00: begin
                    new_be    = 4'b0001 << addr[1:0];
                    new_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    new_be    = addr[1] ? 4'b1100 : 4'b0011;
                    new_wdata = {2{wdata[15:0]}};
                end
                default: new_wdata = wdata;
            endcase
        end
    end

    always_comb begin
        shifted = mem.mem_rdata >> {req_q.addr[1:0], 3'b000};
        unique case (req_q.size)
            2'b00:   ld_data = {{24{req_q.sign & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = {{16{req_q.sign & shifted[15]}}, shifted[15:0]};
            default: ld_data = mem.mem_rdata;
        endcase
    end

    // NOTE: every output and next-state variable gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        fault   = 1'b0;
        rdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (req_ok) begin
                    stall       = 1'b1;
                    req_d.we    = MemWrite;
                    req_d.addr  = addr;
                    req_d.be    = new_be;
                    req_d.wdata = new_wdata;
                    req_d.size  = funct3[1:0];
                    req_d.sign  = ~funct3[2];
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    rdata_d     = '0;
                    state_d     = BUSY;
                end else if (req_bad) begin
                    fault = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // A response in the final allowed cycle still wins over the timeout.
                if (mem.mem_ready) begin
                    rdata_d = req_q.we ? '0 : ld_data;
                    state_d = DONE;
                end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                fault   = err_q;
                rdata   = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem.mem_req   = (state_q == BUSY);
    assign mem.mem_we    = req_q.we & mem.mem_req;
    assign mem.mem_addr  = {req_q.addr[31:2], 2'b00};
    assign mem.mem_be    = req_q.be;
    assign mem.mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses, each predicted by an arithmetic model of the access rules.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, fault;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .rdata    (rdata),
        .fault    (fault),
        .mem      (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] s;
        logic [31:0] v;
        s = w >> (8 * a[1:0]);
        case (f3)
            3'd0: begin v = s % 32'd256;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = s % 32'd65536; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = s % 32'd256;
            3'd5: v = s % 32'd65536;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic idle_inputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'd0;
        addr     = '0;
        wdata    = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
    endtask

    // One full access. delay = BUSY cycle carrying mem_ready; delay > TO never answers.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rword, input int delay);
        logic        st, req, legal, ok, timed_out;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          n;
        st    = wr;
        req   = rd | wr;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok    = req && legal && (a % n == 0);
        exp_be = 4'hF;
        exp_wd = wd;
        if (st && n == 1) begin exp_be = 4'(1 << a[1:0]);     exp_wd = (wd % 32'd256)   * 32'h0101_0101; end
        if (st && n == 2) begin exp_be = a[1] ? 4'hC : 4'h3;   exp_wd = (wd % 32'd65536) * 32'h0001_0001; end

        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
        mem_bus.mem_ready = 1'b0;
        #1;
        check("idle_stall", 32'(stall), 32'(ok));
        check("idle_fault", 32'(fault), 32'(req && !ok));
        check("idle_req",   32'(mem_bus.mem_req), 32'd0);
        check("idle_rdata", rdata, 32'd0);
        if (!ok) begin
            @(negedge clk);
            idle_inputs();
            #1;
            check("stay_idle_req",   32'(mem_bus.mem_req), 32'd0);
            check("stay_idle_stall", 32'(stall), 32'd0);
            return;
        end

        timed_out = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            mem_bus.mem_ready = (k == delay);
            mem_bus.mem_rdata = (k == delay) ? rword : $urandom;
            #1;
            check("busy_req",   32'(mem_bus.mem_req), 32'd1);
            check("busy_stall", 32'(stall), 32'd1);
            check("busy_we",    32'(mem_bus.mem_we), 32'(st));
            check("busy_addr",  mem_bus.mem_addr, a & 32'hFFFF_FFFC);
            check("busy_be",    32'(mem_bus.mem_be), 32'(exp_be));
            if (st) check("busy_wdata", mem_bus.mem_wdata, exp_wd);
            if (k == delay) begin
                timed_out = 1'b0;
                break;
            end
        end

        // Request inputs stay asserted through DONE: no new access may start there.
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        #1;
        check("done_stall", 32'(stall), 32'd0);
        check("done_req",   32'(mem_bus.mem_req), 32'd0);
        check("done_we",    32'(mem_bus.mem_we), 32'd0);
        check("done_fault", 32'(fault), 32'(timed_out));
        check("done_rdata", rdata, (timed_out || st) ? 32'd0 : load_model(f3, a, rword));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        // Access inputs present during reset must be ignored.
        MemRead = 1'b1; funct3 = 3'd2; addr = 32'h0000_0001;
        @(negedge clk); #1;
        check("rst_fault_masked", 32'(fault), 32'd0);
        check("rst_stall_masked", 32'(stall), 32'd0);
        addr = 32'h0000_0000;
        @(negedge clk); #1;
        check("rst_stall_masked2", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_stall",  32'(stall), 32'd0);
        check("rst_fault",  32'(fault), 32'd0);
        check("rst_rdata",  rdata, 32'd0);
        check("rst_req",    32'(mem_bus.mem_req), 32'd0);
        check("rst_we",     32'(mem_bus.mem_we), 32'd0);
        check("rst_be",     32'(mem_bus.mem_be), 32'd0);
        check("rst_addr",   mem_bus.mem_addr, 32'd0);
        check("rst_wdata",  mem_bus.mem_wdata, 32'd0);

        access(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1);
        access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 3);
        access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h0, 1);
        access(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 1);
        access(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'hDEAD_BEEF, TO + 1);
        access(1'b1, 1'b0, 3'd1, 32'h402, 32'h0, 32'h8123_0000, TO);
        access(1'b0, 1'b1, 3'd4, 32'h0,   32'h55, 32'h0, 1);
        access(1'b1, 1'b1, 3'd0, 32'h3,   32'hA5, 32'h0, 2);
        access(1'b0, 1'b1, 3'd2, 32'h10,  32'hCAFE_F00D, 32'h0, 1);
        access(1'b1, 1'b0, 3'd5, 32'h2,   32'h0, 32'h8001_0000, 2);

        // Reset during the second BUSY cycle abandons the load silently.
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'd0; addr = 32'h1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_busy_req", 32'(mem_bus.mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("abandon_req",   32'(mem_bus.mem_req), 32'd0);
        check("abandon_stall", 32'(stall), 32'd0);
        check("abandon_fault", 32'(fault), 32'd0);
        access(1'b1, 1'b0, 3'd4, 32'h3, 32'h0, 32'hAA00_0000, 1);

        for (int i = 0; i < 60; i++) begin
            access(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(1, TO + 1)));
        end

        @(negedge clk);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, the maximum number of cycles spent in BUSY waiting for mem_ready before an error is reported; legal range 1..255.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 MemRead  input  1  the core requests a load this instruction.
REQ-005 MemWrite  input  1  the core requests a store this instruction; if MemRead and MemWrite are both high, the store takes priority.
REQ-006 funct3  input  3  access size and sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 wdata  input  32  store data (rs2).
REQ-009 stall  output  1  holds the core's PC and register write.
REQ-010 rdata  output  32  load result, aligned and extended.
REQ-011 fault  output  1  one-cycle pulse: misaligned access, illegal funct3, or timeout.
REQ-012 mem_req  output  1  memory request valid.
REQ-013 mem_we  output  1  write strobe, qualified by mem_req.
REQ-014 mem_addr  output  32  word address: {addr[31:2],2'b00}.
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_ready  input  1  memory accepts the write, or returns read data, this cycle.
REQ-018 mem_rdata  input  32  read word, valid when mem_ready is high.

Function
REQ-019 The unit SHALL implement the states IDLE, BUSY and DONE.
REQ-020 IDLE, no access requested: stall=0, mem_req=0; the unit SHALL remain in IDLE.
REQ-021 IDLE, legal aligned access: stall=1 combinationally in the same cycle; the request fields (we, addr, be, wdata, size, sign) SHALL be registered; next state BUSY.
REQ-022 Alignment rule: a half access requires addr[0]=0; a word access requires addr[1:0]=00.
REQ-023 IDLE, misaligned access or illegal funct3 (any value other than 000/001/010/100/101 for loads, or 000/001/010 for stores): fault=1 and stall=0 in the same cycle, rdata=0, no mem_req; the unit SHALL remain in IDLE.
REQ-024 BUSY: mem_req=1, with all mem_* outputs driven from registers and held stable until the cycle in which mem_ready=1.
REQ-025 BUSY, mem_ready=1: the unit SHALL capture mem_rdata on a load, then go to DONE; mem_req SHALL be low in the following cycle.
REQ-026 BUSY timeout: a counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ready.
REQ-027 When the counter reaches TIMEOUT, the unit SHALL go to DONE with an error flag set and mem_req low.
REQ-028 If mem_ready arrives in the same cycle that the counter reaches TIMEOUT, the unit SHALL treat it as a success.
REQ-029 DONE: stall=0 for exactly one cycle; rdata SHALL present the captured load result, or 0 for a store or an error; fault=1 only when the error flag is set.
REQ-030 DONE SHALL go to IDLE unconditionally and SHALL NOT start a new request in that cycle.
REQ-031 Store byte enables: SB gives mem_be = 1<<addr[1:0] and mem_wdata = {4{wdata[7:0]}}.
REQ-032 Store byte enables: SH gives mem_be = addr[1] ? 1100 : 0011 and mem_wdata = {2{wdata[15:0]}}.
REQ-033 Store byte enables: SW gives mem_be = 1111 and mem_wdata = wdata.
REQ-034 Loads SHALL drive mem_we=0 and mem_be=1111.
REQ-035 Load extraction: select the byte or half indicated by addr[1:0]; sign-extend for 000 and 001, zero-extend for 100 and 101, pass the word through for 010.
REQ-036 Outside DONE, and outside a REQ-023 fault cycle, rdata SHALL be 0.
REQ-037 mem_we SHALL be 0 whenever mem_req is 0.

Reset
REQ-038 While reset is high at a clock edge, next state SHALL be IDLE, the counter and error flag SHALL be 0, and all registered request fields SHALL be 0.
REQ-039 After that edge: stall=0, fault=0, rdata=0, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0.
REQ-040 Reset asserted in BUSY SHALL abandon the transaction: mem_req=0 from the next cycle, and no fault is issued.
REQ-041 Access inputs SHALL be ignored in the cycle in which reset is high.

Verification
REQ-042 LB: addr=0x103, mem_rdata=0x80FF_0000, mem_ready on the 3rd BUSY cycle -> mem_addr=0x100, stall high for 4 cycles, DONE rdata=0xFFFF_FF80.
REQ-043 SH: addr=0x202, wdata=0x1234_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, mem_ready immediate -> exactly one DONE cycle with rdata=0.
REQ-044 LW: addr=0x101 -> fault=1 and stall=0 in the same cycle, no mem_req, state stays IDLE.
REQ-045 TIMEOUT=4, load, mem_ready never asserted -> mem_req high for 4 cycles, then DONE with fault=1 and rdata=0.
REQ-046 Reset in the 2nd BUSY cycle -> next cycle: mem_req=0, stall=0, fault=0; a following LBU at addr=0x3 with mem_rdata=0xAA00_0000 -> rdata=0x0000_00AA.
REQ-047 Back-to-back SW then LHU (addr=0x2, mem_rdata=0x8001_0000) -> DONE, then IDLE for one cycle, then the second request; LHU result 0x0000_8001.
